// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared types and constants for the instruction memory boot loader
//
// Purpose: state encoding, frame constants and address helper used by
// imem_boot_loader and byte_word_assembler.
// Ports: none (package).

package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Frame header is LEN_LO followed by LEN_HI.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte address of instruction word idx relative to the image base.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [15:0] idx);
    return base + (32'(idx) * 32'(BYTES_PER_WORD));
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - packs a little-endian byte stream into 32-bit words
//
// Purpose: byte k of each word lands in bits [8k+7:8k]. word_o presents the
// word including the byte being accepted this cycle, so the caller can
// register a complete word on the same edge that takes the last byte.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear_i      drop any partial word and restart at byte 0
//   byte_valid_i a byte is being accepted this cycle
//   byte_i       the byte being accepted
//   byte_idx_o   lane the next accepted byte will fill (0..3)
//   word_o       staged word with the current byte merged in
//   word_ready_o pulses in the cycle the fourth byte of a word is accepted

import boot_loader_pkg::*;

module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] stage_q, stage_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] merged;

  always_comb begin
    merged = stage_q;
    case (idx_q)
      2'd0:    merged[7:0]   = byte_i;
      2'd1:    merged[15:8]  = byte_i;
      2'd2:    merged[23:16] = byte_i;
      default: merged[31:24] = byte_i;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    idx_d   = idx_q;
    if (clear_i) begin
      stage_d = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      stage_d = merged;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      idx_q   <= '0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_idx_o   = idx_q;
  assign word_o       = merged;
  assign word_ready_o = byte_valid_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a framed byte-stream program image into instruction memory
//
// Purpose: parses LEN_LO, LEN_HI, 4*N data bytes and a CHK byte, writes each
// assembled word to instruction memory and holds the core in reset until the
// whole image is in and its XOR checksum matches.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        begin a load (honoured in IDLE, DONE, ERROR)
//   rx_data      incoming byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle
//   imem_we      one-cycle write strobe per word
//   imem_addr    byte address of the word being written
//   imem_wdata   word being written
//   cpu_reset_n  active-low core reset, high only while DONE
//   load_done    image loaded, checksum good
//   load_error   load aborted (length, checksum or timeout)

import boot_loader_pkg::*;

module imem_boot_loader #(
  parameter int          IMEM_DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [16:0] DEPTH_W  = 17'(IMEM_DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] tmo_q, tmo_d;

  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cpu_rst_n_q, done_q, error_q;

  logic        accept;
  logic        in_frame;
  logic        asm_clear;
  logic        asm_valid;
  logic [1:0]  asm_idx;
  logic [31:0] asm_word;
  logic        asm_ready;
  logic [15:0] len_full;

  assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign rx_ready = in_frame;
  assign accept   = rx_valid && rx_ready;
  assign asm_valid = accept && (state_q == ST_DATA);
  assign len_full = {rx_data, len_q[7:0]};

  byte_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data),
    .byte_idx_o   (asm_idx),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    word_idx_d = word_idx_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_clear  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN_LO;
          len_d      = '0;
          chk_d      = '0;
          word_idx_d = '0;
          tmo_d      = '0;
          asm_clear  = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          chk_d      = chk_q ^ rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          chk_d = chk_q ^ rx_data;
          if (len_full == 16'd0)
            state_d = ST_CHECK;
          else if ({1'b0, len_full} > DEPTH_W)
            state_d = ST_ERROR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data;
          if (asm_ready) begin
            we_d       = 1'b1;
            addr_d     = word_byte_addr(BASE_ADDR, word_idx_q);
            wdata_d    = asm_word;
            word_idx_d = word_idx_q + 16'd1;
            if ((word_idx_q + 16'd1) == len_q)
              state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept)
          state_d = (rx_data == chk_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Inactivity watchdog: any accepted byte re-arms it; an idle cycle on
    // the last count aborts the frame.
    if (in_frame) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q >= TMO_LAST) begin
        state_d = ST_ERROR;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      word_idx_q  <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      word_idx_q  <= word_idx_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // Status follows the next state so it is valid from the first cycle
      // spent in DONE/ERROR and drops the cycle after a restart.
      cpu_rst_n_q <= (state_d == ST_DONE);
      done_q      <= (state_d == ST_DONE);
      error_q     <= (state_d == ST_ERROR);
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = cpu_rst_n_q;
  assign load_done   = done_q;
  assign load_error  = error_q;

  logic unused_ok;
  assign unused_ok = ^asm_idx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  int checks;
  int errors;

  int          wr_total;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  imem_boot_loader #(
    .IMEM_DEPTH     (256),
    .BASE_ADDR      (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial wr_total = 0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr[wr_total % 64] = imem_addr;
      wr_data[wr_total % 64] = imem_wdata;
      wr_total = wr_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: rx_ready=%b required 1 within 200 cycles", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({imem_we, rx_ready, cpu_reset_n, load_done, load_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: we/rdy/crn/done/err=%b required 00000",
               {imem_we, rx_ready, cpu_reset_n, load_done, load_error});
    end
    checks++;
    if ({imem_addr, imem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_single_word();
    int base;
    base = wr_total;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    checks++;
    if (load_done !== 1'b1 || cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b crn=%b required 1 1", load_done, cpu_reset_n);
    end
    checks++;
    if (wr_total - base !== 1) begin
      errors++;
      $display("FAIL single_strobes: got %0d required 1", wr_total - base);
    end
    checks++;
    if (wr_addr[base % 64] !== 32'h0 || wr_data[base % 64] !== 32'h0000_0013) begin
      errors++;
      $display("FAIL single_word: addr=%h data=%h required 00000000 00000013",
               wr_addr[base % 64], wr_data[base % 64]);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    logic [7:0] frame [0:10];
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'h10, 8'h00, 8'hC4};
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
    tick();
    checks++;
    if (load_error !== 1'b1 || cpu_reset_n !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL badchk_flags: err=%b crn=%b done=%b required 1 0 0",
               load_error, cpu_reset_n, load_done);
    end
    checks++;
    if (wr_total - base !== 2) begin
      errors++;
      $display("FAIL badchk_strobes: got %0d required 2", wr_total - base);
    end
    checks++;
    if (wr_addr[base % 64] !== 32'h0 || wr_data[base % 64] !== 32'h0050_0093) begin
      errors++;
      $display("FAIL badchk_w0: addr=%h data=%h required 00000000 00500093",
               wr_addr[base % 64], wr_data[base % 64]);
    end
    checks++;
    if (wr_addr[(base + 1) % 64] !== 32'h4 || wr_data[(base + 1) % 64] !== 32'h0010_0113) begin
      errors++;
      $display("FAIL badchk_w1: addr=%h data=%h required 00000004 00100113",
               wr_addr[(base + 1) % 64], wr_data[(base + 1) % 64]);
    end
  endtask

  task automatic test_oversize();
    int base;
    base = wr_total;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_err: err=%b rdy=%b required 1 0", load_error, rx_ready);
    end
    repeat (4) tick();
    checks++;
    if (wr_total - base !== 0) begin
      errors++;
      $display("FAIL oversize_strobes: got %0d required 0", wr_total - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    int n;
    base = wr_total;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    n = 0;
    while (load_error !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d required 16", n);
    end
    checks++;
    if (wr_total - base !== 0) begin
      errors++;
      $display("FAIL timeout_strobes: got %0d required 0", wr_total - base);
    end
  endtask

  task automatic test_async_reset();
    int base;
    base = wr_total;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_we, rx_ready, cpu_reset_n, load_done, load_error} !== 5'b0 ||
        {imem_addr, imem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b addr=%h wdata=%h required 00000 0 0",
               {imem_we, rx_ready, cpu_reset_n, load_done, load_error}, imem_addr, imem_wdata);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    send_byte(8'h23, 0);
    checks++;
    if (wr_total - base !== 1 || wr_data[base % 64] !== 32'hDEAD_BEEF || wr_addr[base % 64] !== 32'h0) begin
      errors++;
      $display("FAIL reload_word: n=%0d addr=%h data=%h required 1 00000000 deadbeef",
               wr_total - base, wr_addr[base % 64], wr_data[base % 64]);
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL reload_done: done=%b required 1", load_done);
    end
  endtask

  task automatic test_stalls_restart();
    int base;
    logic [31:0] words [0:3];
    logic [7:0]  chk;
    logic [7:0]  b;
    words = '{32'h1122_3344, 32'hA5A5_5A5A, 32'h0000_0000, 32'hFFFF_FFFF};
    chk = 8'h04 ^ 8'h00;
    base = wr_total;
    pulse_start();
    send_byte(8'h04, $urandom_range(0, 3));
    send_byte(8'h00, $urandom_range(0, 3));
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[w][8*k +: 8];
        chk = chk ^ b;
        if (w == 1 && k == 1) pulse_start();
        send_byte(b, $urandom_range(0, 3));
      end
    end
    send_byte(chk, $urandom_range(0, 3));
    checks++;
    if (wr_total - base !== 4 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_count: n=%0d done=%b required 4 1", wr_total - base, load_done);
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (wr_addr[(base + w) % 64] !== 32'(4 * w) || wr_data[(base + w) % 64] !== words[w]) begin
        errors++;
        $display("FAIL stall_word%0d: addr=%h data=%h required %h %h", w,
                 wr_addr[(base + w) % 64], wr_data[(base + w) % 64], 32'(4 * w), words[w]);
      end
    end
    tick();
    start = 1'b1;
    checks++;
    if (cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL restart_before: crn=%b required 1", cpu_reset_n);
    end
    tick();
    start = 1'b0;
    checks++;
    if (cpu_reset_n !== 1'b0 || load_done !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_after: crn=%b done=%b rdy=%b required 0 0 1",
               cpu_reset_n, load_done, rx_ready);
    end
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++;
    if (load_done !== 1'b1 || wr_total - base !== 4) begin
      errors++;
      $display("FAIL empty_image: done=%b n=%0d required 1 4", load_done, wr_total - base);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    test_reset();
    tick();
    reset = 1'b1;
    tick();
    test_single_word();
    test_bad_checksum();
    test_oversize();
    test_timeout();
    test_async_reset();
    test_stalls_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle core.
- Receives a framed program image as a byte stream and assembles it into little-endian 32-bit words.
- Writes those words into the instruction memory through its write port.
- Holds the core in reset (cpu_reset_n low) until the complete image has been loaded and its checksum verified, then releases it.

Parameters:
- IMEM_DEPTH, 256, instruction memory capacity in 32-bit words; also the maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word (matches the PC reset value).
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between accepted bytes while a load is in progress.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte. A byte transfers on a rising edge where rx_valid && rx_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  instruction word being written.
- cpu_reset_n  output  1  active-low reset to the core (PC, register file).
- load_done  output  1  image loaded and checksum correct.
- load_error  output  1  load aborted (bad length, bad checksum, or timeout).

Behaviour:
- Reset: while reset is low, all state clears asynchronously.
  - Reset values: state=IDLE; rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, load_done=0, load_error=0.
  - Reset mid-load aborts the load. A partially assembled word is never written.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (least significant byte first per word), then one CHK byte.
  - CHK is the XOR of every LEN and data byte.
- States:
  - IDLE: rx_ready=0, cpu_reset_n=0. start -> LEN_LO. On entry to LEN_LO: clear checksum, word index, byte index and timeout counter.
  - LEN_LO: rx_ready=1. On accept, capture len[7:0] -> LEN_HI.
  - LEN_HI: rx_ready=1. On accept, capture len[15:8], then:
    - N==0 -> CHECK;
    - N>IMEM_DEPTH -> ERROR (no writes occur);
    - otherwise -> DATA.
  - DATA: rx_ready=1.
    - Byte k of a word (k=0..3) goes into bits [8k+7:8k] of the staging register.
    - On accepting byte 3, imem_we=1 on the next cycle, with imem_addr=BASE_ADDR+4*word_idx and imem_wdata equal to the staged word. word_idx then increments.
    - The write strobe is exactly one cycle wide. A new byte may be accepted in the same cycle as the strobe (staging register is separate from the output register).
    - After word N-1 is accepted -> CHECK.
  - CHECK: rx_ready=1. On accept, the received byte == running XOR -> DONE, otherwise -> ERROR.
  - DONE: load_done=1, cpu_reset_n=1 (registered, so high from the first cycle in DONE), rx_ready=0.
  - ERROR: load_error=1, cpu_reset_n=0, rx_ready=0.
- Restart: start in DONE or ERROR -> LEN_LO. This clears load_done/load_error and drives cpu_reset_n low on the next cycle.
- start in any other state is ignored.
- Timeout: in LEN_LO, LEN_HI, DATA and CHECK, a counter increments every cycle without an accepted byte and clears on every accept.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- Back-pressure: rx_valid may deassert at any time. Bytes are never dropped or duplicated.
- rx_valid while rx_ready=0 is ignored.
- imem_addr and imem_wdata hold their last written values between strobes.

Decomposition:
- Package boot_loader_pkg holds:
  - the state enumeration (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - the header length constant (2 bytes);
  - bytes per word (4).
- One sub-module, byte_word_assembler:
  - byte shift-in, 2-bit byte index, word_ready pulse;
  - clear input driven by the FSM.
- The top level holds the FSM, checksum, word counter, timeout counter and output registers.

Test Plan:
- Single word: start, then bytes 01 00 13 00 00 00 12 with no gaps.
  - Exactly one imem_we, addr=0x0, data=0x00000013.
  - load_done=1 and cpu_reset_n=1 one cycle after the CHK byte is accepted.
- Bad checksum: N=2, words 0x00500093 and 0x00100113, CHK off by one.
  - Two strobes at addr 0x0 and 0x4, then load_error=1, cpu_reset_n stays 0.
- Oversize: LEN bytes 01 01 (N=257, IMEM_DEPTH=256).
  - ERROR immediately after LEN_HI, zero strobes.
- Timeout: TIMEOUT_CYCLES=16; stop rx_valid after 2 data bytes.
  - load_error=1 exactly 16 cycles after the last accept, no strobe.
- Async reset: drive reset low after 2 data bytes.
  - All outputs at reset values immediately.
  - Reload after release writes a correct word with no stale bytes.
- Stalls and restart:
  - Random rx_valid gaps during a 4-word load -> words correct at 0x0..0xC.
  - start pulsed mid-DATA is ignored.
  - start in DONE drops cpu_reset_n next cycle.
